// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// No logic of its own; zero latency.
// No flow control; types only.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic {
    SRC_RF  = 1'b0,
    SRC_ALU = 1'b1
  } src_t;

  localparam int BUSY_TMO_DEF = 4;

  // Bits needed to hold a busy-wait count in the range 0..tmo.
  function automatic int cnt_width(input int tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with per-source masks.
// Purely combinational: grant is valid in the same cycle as the requests.
// No backpressure; the caller decides whether to act on the grant.
module rr_arb2 import uart_tx_sched_pkg::*; (
  input  logic req_rf,
  input  logic req_alu,
  input  logic mask_rf,
  input  logic mask_alu,
  input  logic last_src,
  output logic gnt_vld,
  output logic gnt_src
);

  logic elig_rf;
  logic elig_alu;

  assign elig_rf  = req_rf  & ~mask_rf;
  assign elig_alu = req_alu & ~mask_alu;

  // On a tie the source that was not served last wins; a lone requester always wins.
  always_comb begin
    gnt_vld = elig_rf | elig_alu;
    gnt_src = SRC_RF;
    if (elig_rf && elig_alu) begin
      gnt_src = (last_src == SRC_ALU) ? SRC_RF : SRC_ALU;
    end else if (elig_alu) begin
      gnt_src = SRC_ALU;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules one-byte RF and two-byte ALU sends onto a single UART transmitter.
// Grant edge to DATA_VALID strobe: 1 cycle; ACK lands on the edge that returns to IDLE.
// Requests wait while UART_BUSY is high in IDLE; a missing busy rise times out with ERR.
module uart_tx_sched import uart_tx_sched_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RF_REQ,
  input  logic [WIDTH-1:0]   RF_DATA,
  input  logic               ALU_REQ,
  input  logic [2*WIDTH-1:0] ALU_DATA,
  input  logic               UART_BUSY,
  output logic [WIDTH-1:0]   P_DATA,
  output logic               DATA_VALID,
  output logic               RF_ACK,
  output logic               ALU_ACK,
  output logic               ERR,
  output logic               SCHED_BUSY
);

  localparam int CW = cnt_width(BUSY_TMO);
  // Last WAIT_BUSY cycle before giving up: the count has then reached BUSY_TMO cycles.
  localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO - 1);

  state_t             state_q, state_d;
  src_t               src_q, src_d;
  src_t               last_q, last_d;
  logic [2*WIDTH-1:0] buf_q, buf_d;
  logic               byte_hi_q, byte_hi_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   p_data_d;
  logic               dv_d;
  logic               rf_ack_d;
  logic               alu_ack_d;
  logic               err_d;

  logic               gnt_vld;
  logic               gnt_src;
  logic               more_bytes;

  // A source whose ACK is showing this cycle is masked so a still-high REQ is not re-granted.
  rr_arb2 u_arb (
    .req_rf   (RF_REQ),
    .req_alu  (ALU_REQ),
    .mask_rf  (RF_ACK),
    .mask_alu (ALU_ACK),
    .last_src (last_q),
    .gnt_vld  (gnt_vld),
    .gnt_src  (gnt_src)
  );

  // Only the ALU has a second byte, and only while the low byte is current.
  assign more_bytes = (src_q == SRC_ALU) && !byte_hi_q;
  assign SCHED_BUSY = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld && !UART_BUSY) state_d = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (UART_BUSY)              state_d = ST_WAIT_DONE;
        else if (cnt_q == TMO_LAST) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (!UART_BUSY) state_d = more_bytes ? ST_SEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the frame datapath.
  always_comb begin
    p_data_d  = P_DATA;
    dv_d      = 1'b0;
    rf_ack_d  = 1'b0;
    alu_ack_d = 1'b0;
    err_d     = 1'b0;
    src_d     = src_q;
    last_d    = last_q;
    buf_d     = buf_q;
    byte_hi_d = byte_hi_q;
    cnt_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_SEND) begin
          src_d     = src_t'(gnt_src);
          last_d    = src_t'(gnt_src);
          byte_hi_d = 1'b0;
          buf_d     = (gnt_src == SRC_ALU) ? ALU_DATA : {{WIDTH{1'b0}}, RF_DATA};
          dv_d      = 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (state_d == ST_WAIT_BUSY) begin
          cnt_d = cnt_q + 1'b1;
        end else if (state_d == ST_IDLE) begin
          // Timeout: finish the request with an error; any remaining byte is dropped.
          err_d     = 1'b1;
          rf_ack_d  = (src_q == SRC_RF);
          alu_ack_d = (src_q == SRC_ALU);
        end
      end
      ST_WAIT_DONE: begin
        if (state_d == ST_SEND) begin
          byte_hi_d = 1'b1;
          dv_d      = 1'b1;
        end else if (state_d == ST_IDLE) begin
          rf_ack_d  = (src_q == SRC_RF);
          alu_ack_d = (src_q == SRC_ALU);
        end
      end
      default: begin
      end
    endcase
    if (dv_d) begin
      p_data_d = byte_hi_d ? buf_d[2*WIDTH-1:WIDTH] : buf_d[WIDTH-1:0];
    end
  end

  // Output and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      RF_ACK     <= 1'b0;
      ALU_ACK    <= 1'b0;
      ERR        <= 1'b0;
      src_q      <= SRC_RF;
      last_q     <= SRC_ALU;
      buf_q      <= '0;
      byte_hi_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      P_DATA     <= p_data_d;
      DATA_VALID <= dv_d;
      RF_ACK     <= rf_ack_d;
      ALU_ACK    <= alu_ack_d;
      ERR        <= err_d;
      src_q      <= src_d;
      last_q     <= last_d;
      buf_q      <= buf_d;
      byte_hi_q  <= byte_hi_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
